// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller: load-use / ID-branch interlocks, multi-cycle
// data-memory freeze with sticky timeout, and saturating stall/flush counters.
module hazard_stall_controller #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       IF_ID_RsAddr_i,
  input  logic [4:0]       IF_ID_RtAddr_i,
  input  logic             ID_UsesRs_i,
  input  logic             ID_UsesRt_i,
  input  logic             ID_Branch_i,
  input  logic             ID_BranchTaken_i,
  input  logic             ID_EX_MemRead_i,
  input  logic             ID_EX_RegWrite_i,
  input  logic [4:0]       ID_EX_RdAddr_i,
  input  logic             EX_MEM_MemRead_i,
  input  logic [4:0]       EX_MEM_RdAddr_i,
  input  logic             Mem_Req_i,
  input  logic             Mem_Ack_i,
  output logic             PC_Write_o,
  output logic             IF_ID_Write_o,
  output logic             IF_ID_Flush_o,
  output logic             ID_EX_Write_o,
  output logic             ID_EX_Bubble_o,
  output logic             EX_MEM_Write_o,
  output logic             MEM_WB_Bubble_o,
  output logic             Mem_Timeout_o,
  output logic [CNT_W-1:0] Stall_Cnt_o,
  output logic [CNT_W-1:0] Flush_Cnt_o
);

  localparam int unsigned TMO_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d, tmo_inc;
  logic               tmo_q, tmo_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic mem_stall, lu, bh, ex_wr, mem_ld, rs_hit, rt_hit, taken;

  // Hazard detection; register 0 never counts as a producer.
  always_comb begin
    ex_wr  = ID_EX_RegWrite_i && (ID_EX_RdAddr_i != '0);
    mem_ld = EX_MEM_MemRead_i && (EX_MEM_RdAddr_i != '0);
    lu     = ID_EX_MemRead_i && (ID_EX_RdAddr_i != '0) &&
             ((ID_UsesRs_i && (ID_EX_RdAddr_i == IF_ID_RsAddr_i)) ||
              (ID_UsesRt_i && (ID_EX_RdAddr_i == IF_ID_RtAddr_i)));
    rs_hit = ID_UsesRs_i && ((ex_wr  && (ID_EX_RdAddr_i  == IF_ID_RsAddr_i)) ||
                             (mem_ld && (EX_MEM_RdAddr_i == IF_ID_RsAddr_i)));
    rt_hit = ID_UsesRt_i && ((ex_wr  && (ID_EX_RdAddr_i  == IF_ID_RtAddr_i)) ||
                             (mem_ld && (EX_MEM_RdAddr_i == IF_ID_RtAddr_i)));
    bh     = ID_Branch_i && (rs_hit || rt_hit);
    taken  = ID_Branch_i && ID_BranchTaken_i;
    mem_stall = ((state_q == RUN) && Mem_Req_i && !Mem_Ack_i) ||
                ((state_q == MEM_WAIT) && !Mem_Ack_i);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (Mem_Req_i && !Mem_Ack_i) state_d = MEM_WAIT;
      MEM_WAIT: if (Mem_Ack_i) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // Control outputs; everything held closed while reset is asserted.
  always_comb begin
    PC_Write_o      = 1'b0;
    IF_ID_Write_o   = 1'b0;
    IF_ID_Flush_o   = 1'b0;
    ID_EX_Write_o   = 1'b0;
    ID_EX_Bubble_o  = 1'b0;
    EX_MEM_Write_o  = 1'b0;
    MEM_WB_Bubble_o = 1'b0;
    if (!rst_i) begin
      if (mem_stall) begin
        MEM_WB_Bubble_o = 1'b1;
      end else if (lu || bh) begin
        ID_EX_Write_o  = 1'b1;
        ID_EX_Bubble_o = 1'b1;
        EX_MEM_Write_o = 1'b1;
      end else begin
        PC_Write_o     = 1'b1;
        IF_ID_Write_o  = 1'b1;
        ID_EX_Write_o  = 1'b1;
        EX_MEM_Write_o = 1'b1;
        IF_ID_Flush_o  = taken;
      end
    end
  end

  always_comb begin
    tmo_inc   = (tmo_cnt_q == '1) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
    tmo_cnt_d = mem_stall ? tmo_inc : '0;
    tmo_d     = tmo_q;
    if ((MEM_TIMEOUT != 0) && mem_stall && (tmo_inc == TMO_W'(MEM_TIMEOUT)))
      tmo_d = 1'b1;
    stall_cnt_d = stall_cnt_q;
    if (!PC_Write_o && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
    flush_cnt_d = flush_cnt_q;
    if (IF_ID_Flush_o && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      tmo_cnt_q   <= '0;
      tmo_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tmo_cnt_q   <= tmo_cnt_d;
      tmo_q       <= tmo_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign Mem_Timeout_o = tmo_q;
  assign Stall_Cnt_o   = stall_cnt_q;
  assign Flush_Cnt_o   = flush_cnt_q;

endmodule
